// File: rtl/core_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_prefetch_pkg
// Purpose  : Shared types for the instruction prefetch unit (word address,
//            instruction word, NOP encoding, buffered entry).
// Revision : 1.0 - initial release
// ============================================================================
package core_prefetch_pkg;

  typedef logic [29:0] ptr;
  typedef logic [31:0] word;

  localparam word NOP = 32'h0000_0013;

  typedef struct packed {
    word  insn;
    ptr   pc;
    logic abort;
  } prefetch_entry;

  // Word addresses wrap modulo 2^30.
  function automatic ptr ptr_inc(input ptr p);
    return p + 30'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : core_prefetch_if
// Purpose  : Instruction bus between the prefetch unit (master) and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface core_prefetch_if;
  import core_prefetch_pkg::*;

  logic fetch;
  ptr   insn_addr;
  logic fetched;
  word  insn_word;
  logic insn_abort;

  modport master (
    output fetch,
    output insn_addr,
    input  fetched,
    input  insn_word,
    input  insn_abort
  );

  modport slave (
    input  fetch,
    input  insn_addr,
    output fetched,
    output insn_word,
    output insn_abort
  );

endinterface
`default_nettype wire

// File: rtl/core_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : core_prefetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO of prefetch entries with clear.
// Revision : 1.0 - initial release
// ============================================================================
module core_prefetch_fifo
  import core_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  prefetch_entry           wr_data,
  output prefetch_entry           rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_aw = $clog2(DEPTH);

  prefetch_entry         r_mem [DEPTH];
  logic [c_aw-1:0]       r_rd;
  logic [c_aw-1:0]       r_wr;
  logic [c_aw:0]         r_count;

  // Clear wins over a same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + c_aw'(1);
      if (pop)  r_rd <= r_rd + c_aw'(1);
      r_count <= r_count + {{c_aw{1'b0}}, push} - {{c_aw{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd];
  assign count   = r_count;
  assign empty   = (r_count == '0);
  assign full    = (r_count == (c_aw + 1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/core_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : core_prefetch
// Purpose  : Instruction prefetch unit: single outstanding bus read, DEPTH-entry
//            buffer, stall/flush handshake. Optional CORE_PREFETCH_BYPASS_EN
//            presents a response into an empty buffer in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module core_prefetch
  import core_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  ptr               target,
  core_prefetch_if.master  bus,
  output word              fetch_insn,
  output ptr               fetch_insn_pc,
  output ptr               fetch_head,
  output logic             fetch_nop,
  output logic             fetch_abort
);

  localparam int                c_cnt_w     = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

  ptr   r_req_ptr;
  ptr   r_head;
  ptr   r_insn_addr;
  logic r_fetch;
  logic r_discard;
  logic r_halted;

  prefetch_entry        w_resp_entry;
  prefetch_entry        w_fifo_rd;
  prefetch_entry        w_front;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_cnt_w-1:0]   w_fifo_count;
  logic [c_cnt_w-1:0]   w_count_next;
  logic                 w_resp;
  logic                 w_fresh;
  logic                 w_bypass;
  logic                 w_present;
  logic                 w_pop;
  logic                 w_fifo_pop;
  logic                 w_push;
  logic                 w_busy_next;
  logic                 w_halted_next;
  logic                 w_issue;
  ptr                   w_ptr_base;

  assign w_resp       = r_fetch & bus.fetched;
  // A response is kept only if it was not made stale by an earlier or current flush.
  assign w_fresh      = w_resp & ~r_discard & ~flush;
  assign w_resp_entry = {bus.insn_word, r_insn_addr, bus.insn_abort};

`ifdef CORE_PREFETCH_BYPASS_EN
  assign w_bypass = w_fifo_empty & w_fresh;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_present  = ~w_fifo_empty | w_bypass;
  assign w_front    = w_bypass ? w_resp_entry : w_fifo_rd;
  assign w_pop      = ~stall & ~flush & w_present;
  assign w_fifo_pop = w_pop & ~w_fifo_empty;
  assign w_push     = w_fresh & ~(w_bypass & w_pop) & (~w_fifo_full | w_fifo_pop);

  assign w_count_next  = flush ? '0
                       : w_fifo_count - {{(c_cnt_w-1){1'b0}}, w_fifo_pop}
                                      + {{(c_cnt_w-1){1'b0}}, w_push};
  assign w_busy_next   = r_fetch & ~bus.fetched;
  assign w_halted_next = ~flush & (r_halted | (w_fresh & bus.insn_abort));
  // Buffered entries plus the outstanding read never exceed DEPTH.
  assign w_issue       = ~w_busy_next & ~w_halted_next & (w_count_next < c_depth_cnt);
  assign w_ptr_base    = flush ? target : r_req_ptr;

  core_prefetch_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .push    (w_push),
    .pop     (w_fifo_pop),
    .wr_data (w_resp_entry),
    .rd_data (w_fifo_rd),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ptr   <= '0;
      r_head      <= '0;
      r_insn_addr <= '0;
      r_fetch     <= 1'b0;
      r_discard   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_fetch   <= w_issue | w_busy_next;
      r_req_ptr <= w_issue ? ptr_inc(w_ptr_base) : w_ptr_base;
      r_halted  <= w_halted_next;
      if (w_issue) r_insn_addr <= w_ptr_base;

      if (flush)      r_head <= target;
      else if (w_pop) r_head <= ptr_inc(r_head);

      // The old request still completes on the bus; its data must be dropped.
      if (flush)       r_discard <= w_busy_next;
      else if (w_resp) r_discard <= 1'b0;
    end
  end

  assign bus.fetch     = r_fetch;
  assign bus.insn_addr = r_insn_addr;

  always_comb begin
    fetch_nop     = ~w_present;
    fetch_abort   = 1'b0;
    fetch_insn    = NOP;
    fetch_insn_pc = r_head;
    if (w_present) begin
      fetch_insn_pc = w_front.pc;
      fetch_abort   = w_front.abort;
      if (!w_front.abort) fetch_insn = w_front.insn;
    end
  end

  assign fetch_head = flush ? target : r_head;

endmodule
`default_nettype wire

// File: tb/tb_core_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_prefetch
// Purpose  : Self-checking bench for core_prefetch with a queue-based model of
//            the program-order instruction stream and a randomized bus slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_prefetch;
  import core_prefetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef CORE_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    word insn;
    ptr  pc;
    bit  abort;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  ptr   target = '0;
  word  fetch_insn;
  ptr   fetch_insn_pc;
  ptr   fetch_head;
  logic fetch_nop;
  logic fetch_abort;

  core_prefetch_if bus_if ();

  core_prefetch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .target        (target),
    .bus           (bus_if.master),
    .fetch_insn    (fetch_insn),
    .fetch_insn_pc (fetch_insn_pc),
    .fetch_head    (fetch_head),
    .fetch_nop     (fetch_nop),
    .fetch_abort   (fetch_abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: program-order stream state and the single tracked bus request.
  ent_t m_buf[$];
  ptr   m_head, m_exp_req;
  bit   m_halted;
  bit   tr_active, tr_stale, tr_abort;
  int   tr_lat;
  ptr   tr_addr;
  int   lat_mode  = 1;
  int   abort_pct = 0;
  bit   abort_en  = 1'b0;
  ptr   abort_at  = '0;
  bit   last_fresh;

  ptr   req_log[$];
  ptr   pop_pc[$];
  bit   pop_ab[$];
  word  pop_insn[$];

  logic cap_fetch, cap_nop;
  ptr   cap_pc, cap_head;

  function automatic word mem_data(input ptr a);
    return {a, 2'b11} ^ 32'hC3A5_0000;
  endfunction

  function automatic ptr pc_at(input int i);
    if (i >= 0 && i < pop_pc.size()) return pop_pc[i];
    return '1;
  endfunction

  function automatic bit ab_at(input int i);
    if (i >= 0 && i < pop_ab.size()) return pop_ab[i];
    return 1'b0;
  endfunction

  function automatic word insn_at(input int i);
    if (i >= 0 && i < pop_insn.size()) return pop_insn[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_buf.delete();
    m_head    = '0;
    m_exp_req = '0;
    m_halted  = 1'b0;
    tr_active = 1'b0;
    tr_stale  = 1'b0;
    tr_lat    = 0;
  endtask

  // One clock cycle: bus slave, input drive, output check and model update.
  task automatic step(input bit st, input bit fl, input ptr tg);
    bit   respond, byp, present, pop;
    ent_t e;
    @(negedge clk);
    total++;
    if (bus_if.fetch === 1'b1) begin
      if (!tr_active) begin
        if (bus_if.insn_addr !== m_exp_req || m_halted || m_buf.size() >= DEPTH) begin
          bad++;
          $display("FAIL req_issue: got addr %0h expected %0h (halted=%0d buffered=%0d)",
                   bus_if.insn_addr, m_exp_req, m_halted, m_buf.size());
        end
        tr_active = 1'b1;
        tr_addr   = bus_if.insn_addr;
        tr_lat    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        tr_stale  = 1'b0;
        tr_abort  = (abort_en && tr_addr == abort_at) ||
                    (int'($urandom_range(0, 99)) < abort_pct);
        m_exp_req = m_exp_req + 30'd1;
        req_log.push_back(bus_if.insn_addr);
      end else if (bus_if.insn_addr !== tr_addr) begin
        bad++;
        $display("FAIL addr_hold: got %0h expected %0h", bus_if.insn_addr, tr_addr);
      end
    end else if (tr_active || (!m_halted && m_buf.size() < DEPTH)) begin
      bad++;
      $display("FAIL fetch_idle: got fetch=%0b expected 1 (pending=%0d buffered=%0d)",
               bus_if.fetch, tr_active, m_buf.size());
    end

    respond = tr_active && tr_lat == 0;
    if (tr_active && !respond) tr_lat--;
    bus_if.fetched    = respond;
    bus_if.insn_word  = respond ? mem_data(tr_addr) : word'($urandom);
    bus_if.insn_abort = respond ? tr_abort : 1'b0;
    stall  = st;
    flush  = fl;
    target = tg;
    #1;
    cap_fetch = bus_if.fetch;
    cap_nop   = fetch_nop;
    cap_pc    = fetch_insn_pc;
    cap_head  = fetch_head;

    last_fresh = respond && !tr_stale && !fl;
    byp = BYP && m_buf.size() == 0 && last_fresh;
    present = 1'b0;
    if (m_buf.size() > 0) begin
      e = m_buf[0];
      present = 1'b1;
    end else if (byp) begin
      e.insn = mem_data(tr_addr); e.pc = tr_addr; e.abort = tr_abort;
      present = 1'b1;
    end

    chk("fetch_head", fetch_head, fl ? tg : m_head);
    chk("fetch_nop", fetch_nop, !present);
    chk("fetch_insn_pc", fetch_insn_pc, present ? e.pc : m_head);
    chk("fetch_insn", fetch_insn, (present && !e.abort) ? e.insn : NOP);
    chk("fetch_abort", fetch_abort, present && e.abort);

    if (fl) begin
      if (tr_active && !respond) tr_stale = 1'b1;
      if (respond) tr_active = 1'b0;
      m_buf.delete();
      m_head    = tg;
      m_exp_req = tg;
      m_halted  = 1'b0;
    end else begin
      pop = !st && present;
      if (pop) begin
        pop_pc.push_back(fetch_insn_pc);
        pop_ab.push_back(fetch_abort);
        pop_insn.push_back(fetch_insn);
        m_head = m_head + 30'd1;
        if (m_buf.size() > 0) void'(m_buf.pop_front());
      end
      if (respond) begin
        tr_active = 1'b0;
        if (!tr_stale) begin
          e.insn = mem_data(tr_addr); e.pc = tr_addr; e.abort = tr_abort;
          if (!(byp && pop)) m_buf.push_back(e);
          if (tr_abort) m_halted = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p, r, pops0;
    bus_if.fetched    = 1'b0;
    bus_if.insn_word  = '0;
    bus_if.insn_abort = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fetch", bus_if.fetch, 0);
    chk("rst_insn_addr", bus_if.insn_addr, 0);
    chk("rst_fetch_insn", fetch_insn, NOP);
    chk("rst_fetch_insn_pc", fetch_insn_pc, 0);
    chk("rst_fetch_head", fetch_head, 0);
    chk("rst_fetch_nop", fetch_nop, 1);
    chk("rst_fetch_abort", fetch_abort, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_fetch", bus_if.fetch, 1);
    chk("first_addr", bus_if.insn_addr, 0);

    // In-order fill with a one-cycle bus.
    lat_mode = 1;
    p = pop_pc.size();
    repeat (14) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) chk("order_pc", pc_at(p + i), i);

    // Long stall: buffer fills to DEPTH and the bus goes idle.
    step(1'b0, 1'b1, 30'h20);
    repeat (14) step(1'b1, 1'b0, '0);
    chk("stall_fetch_idle", cap_fetch, 0);
    chk("stall_nop", cap_nop, 0);
    chk("stall_pc", cap_pc, 30'h20);
    p = pop_pc.size();
    repeat (10) step(1'b0, 1'b0, '0);
    chk("resume_first", pc_at(p), 30'h20);
    chk("resume_fourth", pc_at(p + 3), 30'h23);

    // Flush to 0x100 while the read of 0x5 is still outstanding.
    lat_mode = 3;
    step(1'b0, 1'b1, 30'h5);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0);
      if (tr_active && tr_addr == 30'h5 && tr_lat >= 1) break;
    end
    r = req_log.size();
    step(1'b0, 1'b1, 30'h100);
    chk("flush_head", cap_head, 30'h100);
    p = pop_pc.size();
    repeat (14) step(1'b0, 1'b0, '0);
    chk("flush_next_req", (r < req_log.size()) ? req_log[r] : '1, 30'h100);
    chk("flush_first_pc", pc_at(p), 30'h100);

    // Response-to-present latency into an empty buffer.
    lat_mode = 2;
    step(1'b1, 1'b1, 30'h200);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0);
      if (last_fresh) break;
    end
    chk("latency_resp_cycle_nop", cap_nop, !BYP);
    step(1'b1, 1'b0, '0);
    chk("latency_next_nop", cap_nop, 0);
    chk("latency_next_pc", cap_pc, 30'h200);

    // Bus fault on address 0x3 halts issue until the next flush.
    lat_mode = 1;
    abort_en = 1'b1;
    abort_at = 30'h3;
    step(1'b0, 1'b1, 30'h0);
    p = pop_pc.size();
    repeat (24) step(1'b0, 1'b0, '0);
    chk("abort_pc", pc_at(p + 3), 30'h3);
    chk("abort_flag", ab_at(p + 3), 1);
    chk("abort_insn", insn_at(p + 3), NOP);
    chk("abort_stops", pop_pc.size() - p, 4);
    chk("abort_fetch_idle", cap_fetch, 0);
    chk("abort_last_req", req_log[req_log.size() - 1], 30'h3);
    abort_en = 1'b0;

    // Flush in the same cycle as a response.
    step(1'b0, 1'b1, 30'h40);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (tr_active && tr_lat == 0) break;
    end
    step(1'b0, 1'b1, 30'h300);
    p = pop_pc.size();
    repeat (8) step(1'b0, 1'b0, '0);
    chk("flush_resp_first_pc", pc_at(p), 30'h300);

    // Reset in the middle of a request.
    lat_mode = 3;
    step(1'b0, 1'b1, 30'h7);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_fetch", bus_if.fetch, 0);
    chk("midrst_nop", fetch_nop, 1);
    chk("midrst_head", fetch_head, 0);
    reset_model();
    bus_if.fetched = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, including targets near the address wrap.
    lat_mode  = -1;
    abort_pct = 2;
    pops0 = pop_pc.size();
    for (int i = 0; i < 3000; i++) begin
      bit st, fl;
      ptr tg;
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 99) < 3);
      tg = ($urandom_range(0, 3) == 0) ? ptr'(30'h3FFF_FFFC + 30'($urandom_range(0, 3)))
                                       : ptr'($urandom);
      step(st, fl, tg);
    end
    chk("random_progress", (pop_pc.size() - pops0) > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
